// File: rtl/axis_switch_nxm.sv
`default_nettype none
// ============================================================================
// Module   : axis_switch_nxm
// Brief    : S_COUNT x M_COUNT AXI4-Stream packet switch routed by tdest,
//            packet-locked per-output arbiters, 2-entry output skid buffers.
//            Define AXIS_SWITCH_ROUND_ROBIN_EN for round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module axis_switch_nxm #(
    parameter int  S_COUNT               = 4,
    parameter int  M_COUNT               = 4,
    parameter int  DATA_WIDTH            = 64,
    parameter bit  KEEP_ENABLE           = (DATA_WIDTH > 8),
    parameter int  KEEP_WIDTH            = DATA_WIDTH / 8,
    parameter bit  ID_ENABLE             = 1,
    parameter int  ID_WIDTH              = 8,
    parameter int  DEST_WIDTH            = $clog2(M_COUNT + 1),
    parameter bit  USER_ENABLE           = 1,
    parameter int  USER_WIDTH            = 1,
    parameter logic [M_COUNT*DEST_WIDTH-1:0] M_BASE = {3'd3, 3'd2, 3'd1, 3'd0},
    parameter logic [M_COUNT*DEST_WIDTH-1:0] M_TOP  = {3'd3, 3'd2, 3'd1, 3'd0},
    parameter logic [M_COUNT*S_COUNT-1:0]    M_CONNECT = {(M_COUNT*S_COUNT){1'b1}},
    parameter bit  ARB_LSB_HIGH_PRIORITY = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [S_COUNT*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic [S_COUNT-1:0]             s_axis_tvalid,
    output logic [S_COUNT-1:0]             s_axis_tready,
    input  logic [S_COUNT-1:0]             s_axis_tlast,
    input  logic [S_COUNT*ID_WIDTH-1:0]    s_axis_tid,
    input  logic [S_COUNT*DEST_WIDTH-1:0]  s_axis_tdest,
    input  logic [S_COUNT*USER_WIDTH-1:0]  s_axis_tuser,
    output logic [M_COUNT*DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [M_COUNT*KEEP_WIDTH-1:0]  m_axis_tkeep,
    output logic [M_COUNT-1:0]             m_axis_tvalid,
    input  logic [M_COUNT-1:0]             m_axis_tready,
    output logic [M_COUNT-1:0]             m_axis_tlast,
    output logic [M_COUNT*ID_WIDTH-1:0]    m_axis_tid,
    output logic [M_COUNT*DEST_WIDTH-1:0]  m_axis_tdest,
    output logic [M_COUNT*USER_WIDTH-1:0]  m_axis_tuser
);
    localparam int c_SW       = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
    localparam int c_MW       = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
    localparam int c_DEST_LSB = USER_WIDTH;
    localparam int c_ID_LSB   = c_DEST_LSB + DEST_WIDTH;
    localparam int c_LAST_BIT = c_ID_LSB + ID_WIDTH;
    localparam int c_KEEP_LSB = c_LAST_BIT + 1;
    localparam int c_DATA_LSB = c_KEEP_LSB + KEEP_WIDTH;
    localparam int c_PW       = c_DATA_LSB + DATA_WIDTH;

    logic [S_COUNT-1:0] active_q, active_d, drop_q, drop_d;
    logic [c_MW-1:0]    sel_q [S_COUNT];
    logic [c_MW-1:0]    sel_d [S_COUNT];
    logic [c_MW-1:0]    w_dec [S_COUNT];
    logic [c_MW-1:0]    w_sel [S_COUNT];
    logic [S_COUNT-1:0] w_match, w_drop, w_ready, w_xfer;
    logic [c_PW-1:0]    w_s_pay [S_COUNT];

    logic [M_COUNT-1:0] busy_q, busy_d, out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic [c_SW-1:0]    grant_q [M_COUNT];
    logic [c_SW-1:0]    grant_d [M_COUNT];
    logic [c_PW-1:0]    out_pay_q [M_COUNT];
    logic [c_PW-1:0]    out_pay_d [M_COUNT];
    logic [c_PW-1:0]    skid_pay_q [M_COUNT];
    logic [c_PW-1:0]    skid_pay_d [M_COUNT];
    logic [S_COUNT-1:0] w_req [M_COUNT];
    logic [c_PW-1:0]    w_in_pay [M_COUNT];
    logic [M_COUNT-1:0] w_in_xfer, w_in_done;
`ifdef AXIS_SWITCH_ROUND_ROBIN_EN
    logic [c_SW-1:0]    prio_q [M_COUNT];
    logic [c_SW-1:0]    prio_d [M_COUNT];
`endif

    // First requester found scanning from start, upward or downward with wrap.
    function automatic logic [c_SW-1:0] f_pick(input logic [S_COUNT-1:0] req,
                                               input int start, input bit up);
        logic [c_SW-1:0] win;
        logic            found;
        int              idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < S_COUNT; k++) begin
            idx = up ? (start + k) % S_COUNT : (start - k + S_COUNT) % S_COUNT;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = c_SW'(idx);
            end
        end
        return win;
    endfunction

    for (genvar s = 0; s < S_COUNT; s++) begin : g_in
        assign w_s_pay[s] = {s_axis_tdata[s*DATA_WIDTH +: DATA_WIDTH],
                             s_axis_tkeep[s*KEEP_WIDTH +: KEEP_WIDTH],
                             s_axis_tlast[s],
                             s_axis_tid[s*ID_WIDTH +: ID_WIDTH],
                             s_axis_tdest[s*DEST_WIDTH +: DEST_WIDTH],
                             s_axis_tuser[s*USER_WIDTH +: USER_WIDTH]};
    end

    // Input side: decode on the first beat, then hold the route until tlast.
    always_comb begin
        for (int s = 0; s < S_COUNT; s++) begin
            w_match[s] = 1'b0;
            w_dec[s]   = '0;
            for (int i = M_COUNT - 1; i >= 0; i--) begin
                if (M_BASE[i*DEST_WIDTH +: DEST_WIDTH] <= s_axis_tdest[s*DEST_WIDTH +: DEST_WIDTH] &&
                    s_axis_tdest[s*DEST_WIDTH +: DEST_WIDTH] <= M_TOP[i*DEST_WIDTH +: DEST_WIDTH] &&
                    M_CONNECT[i*S_COUNT + s]) begin
                    w_match[s] = 1'b1;
                    w_dec[s]   = c_MW'(i);
                end
            end
            w_sel[s]   = active_q[s] ? sel_q[s] : w_dec[s];
            w_drop[s]  = active_q[s] ? drop_q[s] : !w_match[s];
            w_ready[s] = rst_n && (w_drop[s] ||
                         (busy_q[w_sel[s]] && grant_q[w_sel[s]] == c_SW'(s) && !skid_valid_q[w_sel[s]]));
            w_xfer[s]  = s_axis_tvalid[s] && w_ready[s];
            sel_d[s]   = w_sel[s];
            drop_d[s]  = w_drop[s];
            if (w_xfer[s] && s_axis_tlast[s])
                active_d[s] = 1'b0;
            else
                active_d[s] = active_q[s] || s_axis_tvalid[s];
        end
    end

    assign s_axis_tready = w_ready;

    // Output side: packet-locked arbiter feeding a two-entry skid buffer.
    always_comb begin
        for (int o = 0; o < M_COUNT; o++) begin
            for (int s = 0; s < S_COUNT; s++)
                w_req[o][s] = s_axis_tvalid[s] && !w_drop[s] && (w_sel[s] == c_MW'(o));
            w_in_pay[o]  = w_s_pay[grant_q[o]];
            w_in_xfer[o] = busy_q[o] && w_xfer[grant_q[o]];
            w_in_done[o] = w_in_xfer[o] && w_in_pay[o][c_LAST_BIT];
            busy_d[o]    = busy_q[o];
            grant_d[o]   = grant_q[o];
`ifdef AXIS_SWITCH_ROUND_ROBIN_EN
            prio_d[o]    = prio_q[o];
            if (w_in_done[o])
                prio_d[o] = c_SW'((int'(grant_q[o]) + 1) % S_COUNT);
`endif
            if (busy_q[o]) begin
                if (w_in_done[o])
                    busy_d[o] = 1'b0;
            end else if (|w_req[o]) begin
                busy_d[o]  = 1'b1;
`ifdef AXIS_SWITCH_ROUND_ROBIN_EN
                grant_d[o] = f_pick(w_req[o], int'(prio_q[o]), 1'b1);
`else
                grant_d[o] = f_pick(w_req[o], ARB_LSB_HIGH_PRIORITY ? 0 : S_COUNT - 1,
                                    ARB_LSB_HIGH_PRIORITY);
`endif
            end

            out_valid_d[o]  = out_valid_q[o];
            out_pay_d[o]    = out_pay_q[o];
            skid_valid_d[o] = skid_valid_q[o];
            skid_pay_d[o]   = skid_pay_q[o];
            if (!out_valid_q[o] || m_axis_tready[o]) begin
                if (skid_valid_q[o]) begin
                    out_valid_d[o]  = 1'b1;
                    out_pay_d[o]    = skid_pay_q[o];
                    skid_valid_d[o] = 1'b0;
                end else begin
                    out_valid_d[o] = w_in_xfer[o];
                    if (w_in_xfer[o])
                        out_pay_d[o] = w_in_pay[o];
                end
            end else if (w_in_xfer[o]) begin
                skid_valid_d[o] = 1'b1;
                skid_pay_d[o]   = w_in_pay[o];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q     <= '0;
            drop_q       <= '0;
            busy_q       <= '0;
            out_valid_q  <= '0;
            skid_valid_q <= '0;
            for (int s = 0; s < S_COUNT; s++) sel_q[s] <= '0;
            for (int o = 0; o < M_COUNT; o++) begin
                grant_q[o] <= '0;
`ifdef AXIS_SWITCH_ROUND_ROBIN_EN
                prio_q[o]  <= '0;
`endif
            end
        end else begin
            active_q     <= active_d;
            drop_q       <= drop_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            for (int s = 0; s < S_COUNT; s++) sel_q[s] <= sel_d[s];
            for (int o = 0; o < M_COUNT; o++) begin
                grant_q[o] <= grant_d[o];
`ifdef AXIS_SWITCH_ROUND_ROBIN_EN
                prio_q[o]  <= prio_d[o];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int o = 0; o < M_COUNT; o++) begin
            out_pay_q[o]  <= out_pay_d[o];
            skid_pay_q[o] <= skid_pay_d[o];
        end
    end

    for (genvar o = 0; o < M_COUNT; o++) begin : g_out
        assign m_axis_tvalid[o] = out_valid_q[o];
        assign m_axis_tlast[o]  = out_pay_q[o][c_LAST_BIT];
        assign m_axis_tdata[o*DATA_WIDTH +: DATA_WIDTH] = out_pay_q[o][c_DATA_LSB +: DATA_WIDTH];
        assign m_axis_tdest[o*DEST_WIDTH +: DEST_WIDTH] = out_pay_q[o][c_DEST_LSB +: DEST_WIDTH];
        assign m_axis_tkeep[o*KEEP_WIDTH +: KEEP_WIDTH] =
            KEEP_ENABLE ? out_pay_q[o][c_KEEP_LSB +: KEEP_WIDTH] : {KEEP_WIDTH{1'b1}};
        assign m_axis_tid[o*ID_WIDTH +: ID_WIDTH] =
            ID_ENABLE ? out_pay_q[o][c_ID_LSB +: ID_WIDTH] : {ID_WIDTH{1'b0}};
        assign m_axis_tuser[o*USER_WIDTH +: USER_WIDTH] =
            USER_ENABLE ? out_pay_q[o][0 +: USER_WIDTH] : {USER_WIDTH{1'b0}};
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_switch_nxm.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_switch_nxm
// Brief    : Directed/randomised bench for axis_switch_nxm with a packet-level
//            routing and arbitration model (AXIS_SWITCH_ROUND_ROBIN_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_switch_nxm;
    localparam int S   = 4;
    localparam int M   = 4;
    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int IW  = 8;
    localparam int DSW = 3;
    localparam int UW  = 1;
    localparam logic [M*S-1:0] c_MASK_B = 16'hFFEF;   // input 0 may not reach output 1

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [KW-1:0]  keep;
        logic           last;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [S*DW-1:0]  s_tdata;
    logic [S*KW-1:0]  s_tkeep;
    logic [S-1:0]     s_tvalid, s_tlast;
    logic [S*IW-1:0]  s_tid;
    logic [S*DSW-1:0] s_tdest;
    logic [S*UW-1:0]  s_tuser;
    logic [M-1:0]     m_tready;

    logic [S-1:0]     s_tready_a, s_tready_b, s_tready;
    logic [M*DW-1:0]  m_tdata_a, m_tdata_b, m_tdata;
    logic [M*KW-1:0]  m_tkeep_a, m_tkeep_b, m_tkeep;
    logic [M-1:0]     m_tvalid_a, m_tvalid_b, m_tvalid;
    logic [M-1:0]     m_tlast_a, m_tlast_b, m_tlast;
    logic [M*IW-1:0]  m_tid_a, m_tid_b, m_tid;
    logic [M*DSW-1:0] m_tdest_a, m_tdest_b, m_tdest;
    logic [M*UW-1:0]  m_tuser_a, m_tuser_b, m_tuser;
    logic             use_b;

    assign s_tready = use_b ? s_tready_b : s_tready_a;
    assign m_tdata  = use_b ? m_tdata_b  : m_tdata_a;
    assign m_tkeep  = use_b ? m_tkeep_b  : m_tkeep_a;
    assign m_tvalid = use_b ? m_tvalid_b : m_tvalid_a;
    assign m_tlast  = use_b ? m_tlast_b  : m_tlast_a;
    assign m_tid    = use_b ? m_tid_b    : m_tid_a;
    assign m_tdest  = use_b ? m_tdest_b  : m_tdest_a;
    assign m_tuser  = use_b ? m_tuser_b  : m_tuser_a;

    axis_switch_nxm u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready_a), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata_a), .m_axis_tkeep(m_tkeep_a), .m_axis_tvalid(m_tvalid_a),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast_a), .m_axis_tid(m_tid_a),
        .m_axis_tdest(m_tdest_a), .m_axis_tuser(m_tuser_a)
    );

    axis_switch_nxm #(.M_CONNECT(c_MASK_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready_b), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata_b), .m_axis_tkeep(m_tkeep_b), .m_axis_tvalid(m_tvalid_b),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast_b), .m_axis_tid(m_tid_b),
        .m_axis_tdest(m_tdest_b), .m_axis_tuser(m_tuser_b)
    );

    beat_t        tx_q  [S][$];
    beat_t        pkt_q [S][$];
    beat_t        rx_q  [M][$];
    beat_t        exp_q [M][$];
    int           pkt_dest [S];
    int           ptr [M];
    int           first_cyc [M];
    int           base_t [M] = '{0, 1, 2, 3};
    int           top_t  [M] = '{0, 1, 2, 3};
    logic [3:0]   rdy_pat [M];
    logic [M*S-1:0] conn;
    int           cyc, launch_cyc, vectors, miscompares;
    bit           chk_bp, chk_drop, bp_armed;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference routing: lowest output whose [base,top] holds tdest and whose mask admits s.
    function automatic int route(input int dest, input int s);
        for (int o = 0; o < M; o++)
            if (dest >= base_t[o] && dest <= top_t[o] && conn[o*S + s]) return o;
        return -1;
    endfunction

    function automatic int pick(input int o, input logic [S-1:0] req);
`ifdef AXIS_SWITCH_ROUND_ROBIN_EN
        int c;
        for (int k = 0; k < S; k++) begin
            c = (ptr[o] + k) % S;
            if (req[c]) return c;
        end
`else
        for (int k = 0; k < S; k++) if (req[k]) return k;
`endif
        return -1;
    endfunction

    function automatic beat_t m_beat(input int i);
        beat_t b;
        b.data = m_tdata[i*DW +: DW];
        b.keep = m_tkeep[i*KW +: KW];
        b.last = m_tlast[i];
        b.id   = m_tid[i*IW +: IW];
        b.dest = m_tdest[i*DSW +: DSW];
        b.user = m_tuser[i*UW +: UW];
        return b;
    endfunction

    task automatic send_pkt(input int s, input int dest, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = {$urandom, $urandom};
            b.keep = 8'($urandom);
            b.last = (k == len - 1);
            b.id   = 8'($urandom);
            b.dest = 3'(dest);
            b.user = 1'($urandom);
            tx_q[s].push_back(b);
            pkt_q[s].push_back(b);
        end
        pkt_dest[s] = dest;
    endtask

    // Packets queued together compete together; winners drain whole packets in turn.
    task automatic model_batch();
        logic [S-1:0] req;
        int w;
        for (int o = 0; o < M; o++) begin
            req = '0;
            for (int s = 0; s < S; s++)
                if (pkt_q[s].size() > 0 && route(pkt_dest[s], s) == o) req[s] = 1'b1;
            while (req != '0) begin
                w = pick(o, req);
                for (int k = 0; k < pkt_q[w].size(); k++) exp_q[o].push_back(pkt_q[w][k]);
                req[w] = 1'b0;
                ptr[o] = (w + 1) % S;
            end
        end
        for (int s = 0; s < S; s++) pkt_q[s].delete();
    endtask

    task automatic step();
        logic [S-1:0] hs;
        beat_t b;
        for (int s = 0; s < S; s++) begin
            if (tx_q[s].size() > 0) begin
                b = tx_q[s][0];
                s_tvalid[s]             = 1'b1;
                s_tdata[s*DW +: DW]     = b.data;
                s_tkeep[s*KW +: KW]     = b.keep;
                s_tlast[s]              = b.last;
                s_tid[s*IW +: IW]       = b.id;
                s_tdest[s*DSW +: DSW]   = b.dest;
                s_tuser[s*UW +: UW]     = b.user;
            end else begin
                s_tvalid[s] = 1'b0;
            end
        end
        for (int i = 0; i < M; i++) m_tready[i] = rdy_pat[i][cyc % 4];
        @(negedge clk);
        hs = s_tvalid & s_tready;
        if (chk_bp) begin
            if (bp_armed) check("bp_s_tready_after_stall", s_tready[0], 0);
            bp_armed = m_tvalid[0] && !m_tready[0] && hs[0];
        end
        if (chk_drop && s_tvalid[2]) begin
            check("drop_s_tready2", s_tready[2], 1);
            check("drop_no_m_tvalid", m_tvalid, 0);
        end
        for (int i = 0; i < M; i++) begin
            if (m_tvalid[i]) begin
                if (first_cyc[i] < 0) first_cyc[i] = cyc;
                if (m_tready[i]) rx_q[i].push_back(m_beat(i));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int s = 0; s < S; s++) if (hs[s]) void'(tx_q[s].pop_front());
    endtask

    task automatic run_batch(input string tag, input int max);
        int n;
        bit pend;
        n = 0;
        launch_cyc = cyc;
        for (int o = 0; o < M; o++) first_cyc[o] = -1;
        while (n < max) begin
            pend = 1'b0;
            for (int s = 0; s < S; s++) if (tx_q[s].size() > 0) pend = 1'b1;
            for (int o = 0; o < M; o++) if (rx_q[o].size() < exp_q[o].size()) pend = 1'b1;
            if (!pend) break;
            step();
            n++;
        end
        repeat (4) step();
        check({tag, "_timeout"}, n < max, 1);
        for (int o = 0; o < M; o++) begin
            check($sformatf("%s_out%0d_count", tag, o), rx_q[o].size(), exp_q[o].size());
            for (int k = 0; k < rx_q[o].size() && k < exp_q[o].size(); k++)
                check($sformatf("%s_out%0d_beat%0d", tag, o, k), rx_q[o][k], exp_q[o][k]);
            rx_q[o].delete();
            exp_q[o].delete();
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            check({tag, "_m_tvalid_a"}, m_tvalid_a, 0);
            check({tag, "_s_tready_a"}, s_tready_a, 0);
            check({tag, "_m_tvalid_b"}, m_tvalid_b, 0);
            check({tag, "_s_tready_b"}, s_tready_b, 0);
            @(posedge clk);
        end
        #1;
        rst_n = 1'b1;
        for (int s = 0; s < S; s++) begin tx_q[s].delete(); pkt_q[s].delete(); end
        for (int o = 0; o < M; o++) begin rx_q[o].delete(); exp_q[o].delete(); ptr[o] = 0; end
    endtask

    initial begin
        int n;
        vectors = 0; miscompares = 0; cyc = 0;
        use_b = 1'b0; conn = '1; chk_bp = 1'b0; chk_drop = 1'b0; bp_armed = 1'b0;
        s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0;
        s_tid = '0; s_tdest = '0; s_tuser = '0; m_tready = '1;
        for (int o = 0; o < M; o++) begin rdy_pat[o] = 4'b1111; ptr[o] = 0; end

        do_reset("reset");

        // Routing: every input to a distinct output at once, latency 2.
        for (int s = 0; s < S; s++) send_pkt(s, 3 - s, 4);
        model_batch();
        run_batch("route", 200);
        for (int o = 0; o < M; o++)
            check($sformatf("route_latency_out%0d", o), first_cyc[o] - launch_cyc, 2);

        // Contention on output 2, then again after a lone packet from input 0.
        send_pkt(0, 2, 3); send_pkt(1, 2, 3);
        model_batch();
        run_batch("contend1", 200);
        send_pkt(0, 2, 2);
        model_batch();
        run_batch("contend_pre", 200);
        send_pkt(0, 2, 3); send_pkt(1, 2, 3);
        model_batch();
        run_batch("contend2", 200);

        // Backpressure on output 0.
        rdy_pat[0] = 4'b1001;
        chk_bp = 1'b1; bp_armed = 1'b0;
        send_pkt(0, 0, 8);
        model_batch();
        run_batch("bp", 300);
        chk_bp = 1'b0; rdy_pat[0] = 4'b1111;

        // Unroutable packet is swallowed, next one delivered.
        chk_drop = 1'b1;
        send_pkt(2, 4, 3);
        model_batch();
        run_batch("drop", 100);
        chk_drop = 1'b0;
        send_pkt(2, 1, 3);
        model_batch();
        run_batch("after_drop", 100);

        // Reset in the middle of a packet.
        send_pkt(0, 0, 5);
        n = 0;
        while (tx_q[0].size() > 3 && n < 20) begin step(); n++; end
        check("midpkt_progress", n < 20, 1);
        do_reset("midreset");
        send_pkt(0, 0, 5);
        model_batch();
        run_batch("post_reset", 200);

        // Connectivity mask on the second instance.
        do_reset("mask_reset");
        use_b = 1'b1;
        conn  = c_MASK_B;
        send_pkt(0, 1, 3); send_pkt(1, 1, 3);
        model_batch();
        run_batch("mask", 200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_switch_nxm.md
Name: axis_switch_nxm

Overview:
- S_COUNT x M_COUNT AXI4-Stream packet switch; every input packet is routed to one output, selected by its tdest.
- Each output has its own arbiter, which holds the grant for a whole packet, from first beat through tlast.
- Sits between stream sources and sinks in the datapath.
- Outputs are registered through a skid buffer, giving full throughput.

Parameters:
- S_COUNT, 4, number of slave (input) ports
- M_COUNT, 4, number of master (output) ports
- DATA_WIDTH, 64, tdata width per port
- KEEP_ENABLE, (DATA_WIDTH>8), carry tkeep; when 0, output tkeep is all ones
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width per port
- ID_ENABLE, 1, carry tid; when 0, output tid is 0
- ID_WIDTH, 8, tid width
- DEST_WIDTH, $clog2(M_COUNT+1), tdest width
- USER_ENABLE, 1, carry tuser; when 0, output tuser is 0
- USER_WIDTH, 1, tuser width
- M_BASE, {3'd3,3'd2,3'd1,3'd0}, packed DEST_WIDTH-bit lowest tdest per output; output i uses slice i
- M_TOP, {3'd3,3'd2,3'd1,3'd0}, packed DEST_WIDTH-bit highest tdest per output, inclusive
- M_CONNECT, all ones, M_COUNT*S_COUNT mask; bit [i*S_COUNT+s] allows input s to reach output i
- ARB_LSB_HIGH_PRIORITY, 1, lower index wins ties and fixed-priority decisions

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  input data, port s at slice s
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  byte enables
- s_axis_tvalid  in  S_COUNT  input valid
- s_axis_tready  out  S_COUNT  input ready
- s_axis_tlast  in  S_COUNT  end of packet
- s_axis_tid  in  S_COUNT*ID_WIDTH  stream id
- s_axis_tdest  in  S_COUNT*DEST_WIDTH  routing destination
- s_axis_tuser  in  S_COUNT*USER_WIDTH  sideband
- m_axis_tdata  out  M_COUNT*DATA_WIDTH  output data
- m_axis_tkeep  out  M_COUNT*KEEP_WIDTH  output byte enables
- m_axis_tvalid  out  M_COUNT  output valid
- m_axis_tready  in  M_COUNT  output ready
- m_axis_tlast  out  M_COUNT  end of packet
- m_axis_tid  out  M_COUNT*ID_WIDTH  passthrough tid
- m_axis_tdest  out  M_COUNT*DEST_WIDTH  passthrough tdest
- m_axis_tuser  out  M_COUNT*USER_WIDTH  passthrough tuser

Behaviour:
- All state changes on rising clk. While rst_n=0:
  - m_axis_tvalid=0 and s_axis_tready=0.
  - Grants, decode state, skid buffers and arbiter pointers are cleared; pointers go to index 0.
  - Packets in flight are abandoned; no tlast is emitted for them.
- Input decode:
  - At the first beat of a packet (input idle, tvalid=1), the selected output is the lowest i where M_BASE[i] <= tdest <= M_TOP[i] and the M_CONNECT bit for (i,s) is set.
  - The selection is latched and held until the tlast beat is accepted. tdest on later beats is ignored for routing.
- No match: the input drops the packet. s_axis_tready=1 for every beat through tlast, and no output sees it.
- Output arbitration:
  - Requesters for output i are inputs whose latched or current decode selects i, with tvalid=1.
  - When the output is idle, the grant is registered in the cycle requests appear. The grant is held until the tlast beat from that input is transferred.
  - The output becomes idle the cycle after tlast transfers; re-arbitration may grant in that same cycle.
- Forwarding:
  - s_axis_tready[s] = granted to the selected output AND that output's skid buffer can accept.
  - A beat transfers on tvalid&tready. Ungranted inputs see tready=0.
- Output register: 2-entry skid buffer per output.
  - m_axis_tready is not combinationally coupled to s_axis_tready.
  - Sustains 1 beat/cycle; stalls without loss when m_axis_tready=0.
- Latency: tvalid at cycle 0 on an idle output produces m_axis_tvalid at cycle 2. Following beats stream back-to-back.
- Ordering: beats of a packet are never interleaved with another packet on the same output. Different outputs operate concurrently.
- Disabled KEEP/ID/USER fields drive constants as listed under Parameters.

Optional Feature:
- AXIS_SWITCH_ROUND_ROBIN_EN defined: each output arbiter is round-robin. After a packet from input g completes, priority starts at g+1, wrapping.
- Undefined: fixed priority per ARB_LSB_HIGH_PRIORITY; with the default, input 0 always wins.

Test Plan:
- Routing: inputs 0..3 each send a 4-beat packet at the same time, with tdest 3,2,1,0. Each output receives exactly its packet intact, data and tid preserved. First beat appears 2 cycles after tvalid.
- Contention: inputs 0 and 1 both send 3-beat packets to tdest 2.
  - With the macro: input 0's packet, then input 1's, with no interleaving.
  - Repeat: input 1 first, then input 0.
  - Without the macro: input 0 wins both times.
- Backpressure: m_axis_tready[0] toggles 1,0,0,1 during an 8-beat packet to output 0. All 8 beats arrive in order with tlast only on beat 8; s_axis_tready falls within 2 beats of the stall.
- Drop: tdest=4 (out of range), 3-beat packet on input 2. s_axis_tready[2]=1 for all beats; no m_axis_tvalid anywhere. A following packet to tdest 1 is delivered normally.
- Reset mid-packet: assert rst_n=0 after beat 2 of 5.
  - During reset: m_axis_tvalid=0 and s_axis_tready=0.
  - After release, a new packet to the same output is delivered complete.
- Masking: M_CONNECT bit (1,0) cleared and input 0 sends with tdest=1. The packet is dropped; input 1 sending tdest=1 is still delivered.
